// File: rtl/ula_timing_pkg.sv
// Raster geometry and interrupt FSM types for the TK90X/TK95 ULA.
// Bounds are 9-bit so they compare directly against the beam counts.
package ula_timing_pkg;

  localparam logic [8:0] H_TOTAL  = 9'd448;
  localparam logic [8:0] V_TOTAL  = 9'd312;
  localparam logic [8:0] H_LAST   = 9'd447;
  localparam logic [8:0] V_LAST   = 9'd311;

  localparam logic [8:0] DISP_W   = 9'd256;
  localparam logic [8:0] DISP_H   = 9'd192;
  localparam logic [8:0] HBLANK_S = 9'd320;
  localparam logic [8:0] HBLANK_E = 9'd415;
  localparam logic [8:0] HSYNC_S  = 9'd344;
  localparam logic [8:0] HSYNC_E  = 9'd375;
  localparam logic [8:0] VBLANK_S = 9'd248;
  localparam logic [8:0] VBLANK_E = 9'd255;
  localparam logic [8:0] VSYNC_S  = 9'd248;
  localparam logic [8:0] VSYNC_E  = 9'd251;

  localparam logic [8:0] INT_LINE = 9'd248;
  localparam logic [6:0] INT_LAST = 7'd63;
  localparam logic [3:0] FLASH_LAST = 4'd15;

  typedef enum logic {
    INT_IDLE,
    INT_ACTIVE
  } int_state_e;

endpackage

// File: rtl/ula_int_gen.sv
// Z80 /INT pulse generator: fixed-length low pulse, no retrigger.
// int_n is registered alongside the FSM so it shares its timing.
module ula_int_gen
  import ula_timing_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic int_n
);

  int_state_e state, state_nx;
  logic [6:0] cnt, cnt_nx;
  logic       int_n_nx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= INT_IDLE;
      cnt   <= '0;
      int_n <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      int_n <= int_n_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    int_n_nx = int_n;
    unique case (state)
      INT_IDLE: begin
        if (start) begin
          state_nx = INT_ACTIVE;
          cnt_nx   = INT_LAST;
          int_n_nx = 1'b0;
        end
      end
      INT_ACTIVE: begin
        if (cnt == 7'd0) begin
          state_nx = INT_IDLE;
          int_n_nx = 1'b1;
        end else begin
          cnt_nx = cnt - 7'd1;
        end
      end
    endcase
  end

endmodule

// File: rtl/ula_sync_gen.sv
// Raster timing decoder: registers sync, blanking, window, ticks,
// /INT and FLASH phase from the beam counts at mid-cell.
module ula_sync_gen
  import ula_timing_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [8:0] hc,
  input  logic [8:0] vc,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       blank,
  output logic       display,
  output logic       border,
  output logic       line_tick,
  output logic       frame_tick,
  output logic       int_n,
  output logic       flash
);

  logic in_range;
  logic hblank, vblank, hsync, vsync;
  logic disp_d, blank_d, line_d, frame_d;
  logic int_start;
  logic [3:0] frame_cnt;

  assign in_range = (hc < H_TOTAL) && (vc < V_TOTAL);
  assign hblank = (hc >= HBLANK_S) && (hc <= HBLANK_E);
  assign vblank = (vc >= VBLANK_S) && (vc <= VBLANK_E);
  assign hsync  = (hc >= HSYNC_S) && (hc <= HSYNC_E);
  assign vsync  = (vc >= VSYNC_S) && (vc <= VSYNC_E);

  // Out-of-range counts look like blanking until the parent wraps them
  assign blank_d = !in_range || hblank || vblank;
  assign disp_d  = in_range && (hc < DISP_W) && (vc < DISP_H);
  assign line_d  = in_range && (hc == H_LAST);
  assign frame_d = line_d && (vc == V_LAST);

  assign int_start = (vc == INT_LINE) && (hc == 9'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hsync_n    <= 1'b1;
      vsync_n    <= 1'b1;
      blank      <= 1'b1;
      display    <= 1'b0;
      border     <= 1'b0;
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
      flash      <= 1'b0;
    end else begin
      hsync_n    <= !(in_range && hsync);
      vsync_n    <= !(in_range && vsync);
      blank      <= blank_d;
      display    <= disp_d;
      border     <= !blank_d && !disp_d;
      line_tick  <= line_d;
      frame_tick <= frame_d;
      if (frame_d) begin
        frame_cnt <= frame_cnt + 4'd1;
        if (frame_cnt == FLASH_LAST) flash <= !flash;
      end
    end
  end

  ula_int_gen u_int (
    .clock (clock),
    .reset (reset),
    .start (int_start),
    .int_n (int_n)
  );

endmodule

// File: tb/tb_ula_sync_gen.sv
// Directed and random checks of ula_sync_gen against a raster model.
// Inputs change on the falling edge; outputs sampled 1 after rising.
module tb_ula_sync_gen;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [8:0] hc = '0;
  logic [8:0] vc = '0;
  logic hsync_n, vsync_n, blank, display, border;
  logic line_tick, frame_tick, int_n, flash;

  int total = 0;
  int bad = 0;
  int rem = 0;
  int frames = 0;
  int n_a, n_b;

  always #5 clock = ~clock;

  ula_sync_gen dut (
    .clock      (clock),
    .reset      (reset),
    .hc         (hc),
    .vc         (vc),
    .hsync_n    (hsync_n),
    .vsync_n    (vsync_n),
    .blank      (blank),
    .display    (display),
    .border     (border),
    .line_tick  (line_tick),
    .frame_tick (frame_tick),
    .int_n      (int_n),
    .flash      (flash)
  );

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs,
                       input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, ".hsync_n"}, hsync_n, 1'b1);
    chk({tag, ".vsync_n"}, vsync_n, 1'b1);
    chk({tag, ".int_n"}, int_n, 1'b1);
    chk({tag, ".blank"}, blank, 1'b1);
    chk({tag, ".display"}, display, 1'b0);
    chk({tag, ".border"}, border, 1'b0);
    chk({tag, ".line_tick"}, line_tick, 1'b0);
    chk({tag, ".frame_tick"}, frame_tick, 1'b0);
    chk({tag, ".flash"}, flash, 1'b0);
  endtask

  // Asserted mid-cycle, checked before any clock edge arrives
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    rem = 0;
    frames = 0;
    chk_rst(tag);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic step(input int h, input int v);
    logic ir, disp, blk, hs, vs, lt, ft;
    @(negedge clock);
    hc = h[8:0];
    vc = v[8:0];
    @(posedge clock);
    #1;
    ir   = (h < 448) && (v < 312);
    disp = ir && (h < 256) && (v < 192);
    blk  = !ir || (h >= 320 && h <= 415) || (v >= 248 && v <= 255);
    hs   = ir && h >= 344 && h <= 375;
    vs   = ir && v >= 248 && v <= 251;
    lt   = ir && h == 447;
    ft   = lt && v == 311;
    if (ft) frames++;
    if (rem > 0) rem--;
    else if (h == 0 && v == 248) rem = 64;
    chk("hsync_n", hsync_n, !hs);
    chk("vsync_n", vsync_n, !vs);
    chk("blank", blank, blk);
    chk("display", display, disp);
    chk("border", border, !blk && !disp);
    chk("line_tick", line_tick, lt);
    chk("frame_tick", frame_tick, ft);
    chk("int_n", int_n, rem == 0);
    chk("flash", flash, ((frames / 16) % 2) == 1);
  endtask

  initial begin
    #1;
    do_reset("rst_init");

    step(350, 10);
    do_reset("rst_midline");
    step(350, 10);
    chk("post_rst.hsync_n", hsync_n, 1'b0);
    chk("post_rst.blank", blank, 1'b1);

    n_a = 0;
    n_b = 0;
    for (int h = 0; h < 448; h++) begin
      step(h, 100);
      if (!hsync_n) n_a++;
      if (line_tick) n_b++;
    end
    chk_i("hsync_len", n_a, 32);
    chk_i("line_tick_cnt", n_b, 1);

    n_a = 0;
    for (int v = 0; v < 312; v++) begin
      step(200, v);
      if (!vsync_n) n_a++;
    end
    chk_i("vsync_lines", n_a, 4);

    n_a = 0;
    for (int h = 0; h < 448; h++) begin
      step(h, 248);
      if (h == 0) chk("int_fall", int_n, 1'b0);
      if (!int_n) n_a++;
    end
    chk_i("int_len", n_a, 64);

    n_a = 0;
    step(447, 310);
    for (int h = 0; h < 448; h++) begin
      step(h, 311);
      if (frame_tick) n_a++;
    end
    chk_i("frame_tick_cnt", n_a, 1);

    for (int h = 0; h <= 20; h++) step(h, 248);
    chk("int_pulse_low", int_n, 1'b0);
    do_reset("rst_in_int");
    n_a = 0;
    for (int h = 21; h < 448; h++) begin
      step(h, 248);
      if (!int_n) n_a++;
    end
    chk_i("int_no_resume", n_a, 0);
    for (int h = 0; h < 70; h++) step(h, 248);

    do_reset("rst_flash");
    for (int k = 1; k <= 64; k++) begin
      step(447, 311);
      if (k % 16 == 0)
        chk("flash_seq", flash, ((k / 16) % 2) == 1);
      step(0, 0);
    end

    step(460, 320);
    step(511, 511);
    step(448, 311);
    step(447, 312);

    repeat (3000) begin
      if ($urandom_range(0, 99) == 0) step(0, 248);
      else step($urandom_range(0, 470), $urandom_range(0, 330));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
